bam_seq_mult_ctrl: RTL and testbench



---
 rtl/bam_pkg.sv | 25 ++
 rtl/bam_row_mask.sv | 22 ++
 rtl/bam_seq_mult_ctrl.sv | 109 ++++++++++
 tb/tb_bam_seq_mult_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared types, width helpers and default constants for the broken-array
// approximate multiplier controller.
package bam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bam_state_t;

  localparam int BAM_N_DEFAULT = 8;
  localparam int BAM_H7        = 7;
  localparam int BAM_V11       = 11;

  // h_cut must be able to express 0..N
  function automatic int bam_hw(input int n);
    return $clog2(n + 1);
  endfunction

  // v_cut must be able to express 0..2N
  function automatic int bam_vw(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/bam_row_mask.sv
// Applies the vertical-cut column rule to one partial-product row:
// bit i of the row survives only when its column i+j is at or above v.
module bam_row_mask
  import bam_pkg::*;
#(
  parameter int N  = BAM_N_DEFAULT,
  parameter int HW = bam_hw(N),
  parameter int VW = bam_vw(N)
) (
  input  logic [N-1:0]  a,
  input  logic [HW-1:0] j,
  input  logic [VW-1:0] v,
  output logic [N-1:0]  row
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_col
      assign row[gi] = a[gi] & ((32'(gi) + 32'(j)) >= 32'(v));
    end
  endgenerate

endmodule

// File: rtl/bam_seq_mult_ctrl.sv
// Sequential BAM multiplier: one partial-product row per clock from row H up
// to row N-1, with valid/ready handshakes on operands and result.
module bam_seq_mult_ctrl
  import bam_pkg::*;
#(
  parameter int N  = BAM_N_DEFAULT,
  parameter int HW = bam_hw(N),
  parameter int VW = bam_vw(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [HW-1:0]  h_cut,
  input  logic [VW-1:0]  v_cut,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int JIW = (N > 1) ? $clog2(N) : 1;

  bam_state_t     state_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [VW-1:0]  v_reg;
  logic [HW-1:0]  j_reg;
  logic [2*N-1:0] acc_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;
  logic           busy_reg;

  logic [N-1:0]   row_masked;
  logic [2*N-1:0] row_term;

  bam_row_mask #(
    .N  (N),
    .HW (HW),
    .VW (VW)
  ) u_row_mask (
    .a   (a_reg),
    .j   (j_reg),
    .v   (v_reg),
    .row (row_masked)
  );

  // In RUN j_reg < N, so the low bits address b_reg directly.
  assign row_term = b_reg[j_reg[JIW-1:0]] ? ({{N{1'b0}}, row_masked} << j_reg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      v_reg         <= '0;
      j_reg         <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            v_reg        <= v_cut;
            j_reg        <= h_cut;
            acc_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= (h_cut >= HW'(N)) ? DONE : RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_reg + row_term;
          j_reg   <= j_reg + 1'b1;
          if (j_reg == HW'(N - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, so the handshake
          // only ever sees a fully settled accumulator.
          if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            out_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign product   = acc_reg;

endmodule

// File: tb/tb_bam_seq_mult_ctrl.sv
// Directed self-checking bench for bam_seq_mult_ctrl (N=8) with hand-computed
// products and latencies measured in clock edges after the accept edge.
module tb_bam_seq_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  h_cut;
  logic [4:0]  v_cut;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_checks;
  int n_fail;

  bam_seq_mult_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .h_cut     (h_cut),
    .v_cut     (v_cut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation for a single accept edge, then scrambles inputs.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic [3:0] th, input logic [4:0] tv);
    in_valid = 1'b1;
    a = ta; b = tb; h_cut = th; v_cut = tv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    h_cut = 4'($urandom); v_cut = 5'($urandom);
  endtask

  // Edges from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", product); end
    $display("reset: in_ready=%b out_valid=%b busy=%b product=%h", in_ready, out_valid, busy, product);
  endtask

  // Runs one op through to the result and checks latency and product.
  task automatic test_product(input string name, input logic [7:0] ta, input logic [7:0] tb,
                              input logic [3:0] th, input logic [4:0] tv,
                              input int exp_lat, input logic [15:0] exp_p);
    int lat;
    start_op(ta, tb, th, tv);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got busy=%b in_ready=%b expected 1/0", name, busy, in_ready);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    n_checks++;
    if (product !== exp_p) begin n_fail++; $display("FAIL %s_product: got %h expected %h", name, product, exp_p); end
    $display("op %s: a=%h b=%h H=%0d V=%0d latency=%0d product=%h", name, ta, tb, th, tv, lat, product);
    release_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_release: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", name, out_valid, in_ready, busy);
    end
    n_checks++;
    if (product !== exp_p) begin n_fail++; $display("FAIL %s_hold_idle: got %h expected %h", name, product, exp_p); end
  endtask

  task automatic test_exact();
    test_product("exact_ff", 8'hFF, 8'hFF, 4'd0, 5'd0, 9, 16'hFE01);
    test_product("exact_ab_cd", 8'hAB, 8'hCD, 4'd0, 5'd0, 9, 16'h88EF);
  endtask

  task automatic test_bam_h7v11();
    test_product("h7v11_ff", 8'hFF, 8'hFF, 4'd7, 5'd11, 2, 16'h7800);
    test_product("h7v11_0f_80", 8'h0F, 8'h80, 4'd7, 5'd11, 2, 16'h0000);
  endtask

  task automatic test_cut_bounds();
    test_product("h8", 8'hAB, 8'hCD, 4'd8, 5'd0, 1, 16'h0000);
    test_product("h15", 8'hFF, 8'hFF, 4'd15, 5'd0, 1, 16'h0000);
    test_product("v16", 8'hFF, 8'hFF, 4'd0, 5'd16, 9, 16'h0000);
    test_product("v15", 8'hFF, 8'hFF, 4'd0, 5'd15, 9, 16'h0000);
    test_product("v14", 8'hFF, 8'hFF, 4'd0, 5'd14, 9, 16'h4000);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_op(8'd3, 8'd5, 4'd0, 5'd0);
    wait_valid(lat);
    n_checks++;
    if (lat != 9) begin n_fail++; $display("FAIL bp_latency: got %0d expected 9", lat); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = 8'(c + 100); b = 8'd7; h_cut = 4'd0; v_cut = 5'd0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'd15) begin
        n_fail++; bad++;
        $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b product=%h expected 1/0/000f", c, out_valid, in_ready, product);
      end
    end
    in_valid = 1'b0;
    $display("backpressure: 5 stalled cycles, %0d bad, product=%h", bad, product);
    release_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(8'd7, 8'd9, 4'd0, 5'd0);
    wait_valid(lat);
    n_checks++;
    if (lat != 9 || product !== 16'd63) begin
      n_fail++; $display("FAIL b2b_first: got latency=%0d product=%h expected 9/003f", lat, product);
    end
    // in_valid is high on the handshake edge (ignored) and the next (accepted)
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd4; b = 8'd4; h_cut = 4'd0; v_cut = 5'd0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || product !== 16'd63) begin
      n_fail++; $display("FAIL b2b_gap: got in_ready=%b product=%h expected 1/003f", in_ready, product);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    n_checks++;
    if (lat != 9 || product !== 16'd16) begin
      n_fail++; $display("FAIL b2b_second: got latency=%0d product=%h expected 9/0010", lat, product);
    end
    $display("back_to_back: second latency=%0d product=%h", lat, product);
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(8'hFF, 8'hFF, 4'd0, 5'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      n_fail++; $display("FAIL midrun_reset: got in_ready=%b out_valid=%b busy=%b product=%h expected 1/0/0/0000", in_ready, out_valid, busy, product);
    end
    $display("reset mid-run: in_ready=%b out_valid=%b product=%h", in_ready, out_valid, product);
    test_product("after_reset", 8'd2, 8'd3, 4'd0, 5'd0, 9, 16'd6);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; h_cut = '0; v_cut = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_exact();
    test_bam_h7v11();
    test_cut_bounds();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
